// File: rtl/booth_r4_mac_seq_pkg.sv
// Shared encodings for the sequential radix-4 Booth multiply-accumulate core:
// sign modes, FSM states, Booth digit controls and the iteration-count helper.
package booth_pkg;

    localparam logic [1:0] SM_UU = 2'b00;
    localparam logic [1:0] SM_US = 2'b01;
    localparam logic [1:0] SM_SU = 2'b10;
    localparam logic [1:0] SM_SS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_ACC  = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    localparam logic [1:0] MAG_0  = 2'd0;
    localparam logic [1:0] MAG_1X = 2'd1;
    localparam logic [1:0] MAG_2X = 2'd2;
    localparam logic [1:0] MAG_3X = 2'd3;

    typedef struct packed {
        logic       neg;
        logic [1:0] mag;
    } booth_dig_t;

    // Radix-4 Booth recoding of {b[2i+1], b[2i], b[2i-1]} into sign + magnitude.
    function automatic booth_dig_t booth_recode(input logic [2:0] win);
        booth_dig_t d;
        case (win)
            3'b000:  begin d.neg = 1'b0; d.mag = MAG_0;  end
            3'b001:  begin d.neg = 1'b0; d.mag = MAG_1X; end
            3'b010:  begin d.neg = 1'b0; d.mag = MAG_1X; end
            3'b011:  begin d.neg = 1'b0; d.mag = MAG_2X; end
            3'b100:  begin d.neg = 1'b1; d.mag = MAG_2X; end
            3'b101:  begin d.neg = 1'b1; d.mag = MAG_1X; end
            3'b110:  begin d.neg = 1'b1; d.mag = MAG_1X; end
            3'b111:  begin d.neg = 1'b0; d.mag = MAG_0;  end
            default: begin d.neg = 1'b0; d.mag = MAG_0;  end
        endcase
        return d;
    endfunction

    // One extra step covers the two extension bits of an unsigned multiplier.
    function automatic int unsigned iter_count(input int unsigned width);
        return width / 32'd2 + 32'd1;
    endfunction

endpackage

// File: rtl/booth_r4_mac_seq_step.sv
// One radix-4 Booth step: recode the 3-bit window and add the selected
// signed multiple of the multiplicand to the running upper partial sum.
module booth_r4_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+3:0] acc_hi,
    input  logic [WIDTH+3:0] m1x,
    input  logic [WIDTH+3:0] m3x,
    output logic [WIDTH+3:0] sum
);

    booth_dig_t       dig_s;
    logic [WIDTH+3:0] mag_s;
    logic [WIDTH+3:0] part_s;

    // Digit recode, multiple select, conditional negate and add.
    always_comb begin
        dig_s = booth_recode(window);
        case (dig_s.mag)
            MAG_0:   mag_s = '0;
            MAG_1X:  mag_s = m1x;
            MAG_2X:  mag_s = {m1x[WIDTH+2:0], 1'b0};
            MAG_3X:  mag_s = m3x;
            default: mag_s = '0;
        endcase
        if (dig_s.neg) begin
            part_s = (~mag_s) + {{(WIDTH+3){1'b0}}, 1'b1};
        end else begin
            part_s = mag_s;
        end
        sum = acc_hi + part_s;
    end

endmodule

// File: rtl/booth_r4_mac_seq.sv
// Sequential radix-4 Booth multiplier-accumulator with valid/ready on both
// sides, output backpressure and a guarded wrap-around accumulator.
module booth_r4_mac_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GUARD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           multiplicand,
    input  logic [WIDTH-1:0]           multiplier,
    input  logic [1:0]                 sign_mode,
    input  logic                       acc_en,
    input  logic                       acc_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH+GUARD-1:0]   out_result,
    output logic                       busy
);

    localparam int ITER  = int'(iter_count(WIDTH));
    localparam int PW    = WIDTH + 4;
    localparam int ACC_W = 2 * WIDTH + GUARD;

    state_t             state_r;
    state_t             state_n;
    logic [ITER-1:0]    iter_r;
    logic [PW-1:0]      m1x_r;
    logic [PW-1:0]      m3x_r;
    logic [PW-1:0]      hi_r;
    logic [WIDTH+1:0]   b_r;
    logic               prev_r;
    logic [1:0]         sm_r;
    logic               acc_en_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   out_result_r;
    logic               out_valid_r;

    logic               accept_s;
    logic               a_sign_s;
    logic               b_sign_s;
    logic [PW-1:0]      a_ext_s;
    logic [PW-1:0]      m3x_s;
    logic [PW-1:0]      sum_s;
    logic [2*WIDTH+5:0] shifted_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               fill_s;
    logic [ACC_W-1:0]   ext_s;
    logic [ACC_W-1:0]   result_s;

    assign in_ready   = (state_r == ST_IDLE);
    assign busy       = (state_r != ST_IDLE);
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign accept_s   = in_valid && (state_r == ST_IDLE);

    assign a_sign_s  = sign_mode[1] & multiplicand[WIDTH-1];
    assign b_sign_s  = sign_mode[0] & multiplier[WIDTH-1];
    assign a_ext_s   = {{4{a_sign_s}}, multiplicand};
    assign m3x_s     = a_ext_s + {a_ext_s[PW-2:0], 1'b0};

    booth_r4_step #(.WIDTH(WIDTH)) u_step (
        .window (
            {b_r[1:0], prev_r}),
        .acc_hi (hi_r),
        .m1x    (m1x_r),
        .m3x    (m3x_r),
        .sum    (sum_s)
    );

    // Upper partial sum and multiplier/product bits shift right together by one digit.
    assign shifted_s = {{2{sum_s[PW-1]}}, sum_s, b_r[WIDTH+1:2]};
    assign prod_s    = {hi_r[WIDTH-3:0], b_r};

    // Product extension to accumulator width and optional accumulate.
    always_comb begin
        fill_s = (sm_r != SM_UU) & prod_s[2*WIDTH-1];
        ext_s  = {{GUARD{fill_s}}, prod_s};
        if (acc_en_r) begin
            result_s = acc_r + ext_s;
        end else begin
            result_s = ext_s;
        end
    end

    // Next-state logic for the operation sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) state_n = ST_CALC;
                else          state_n = ST_IDLE;
            end
            ST_CALC: begin
                if (iter_r[ITER-1]) state_n = ST_ACC;
                else                state_n = ST_CALC;
            end
            ST_ACC:  state_n = ST_HOLD;
            ST_HOLD: begin
                if (out_valid_r && out_ready) state_n = ST_IDLE;
                else                          state_n = ST_HOLD;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Operand capture and Booth iteration datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_r   <= '0;
            m1x_r    <= '0;
            m3x_r    <= '0;
            hi_r     <= '0;
            b_r      <= '0;
            prev_r   <= 1'b0;
            sm_r     <= SM_UU;
            acc_en_r <= 1'b0;
        end else if (accept_s) begin
            iter_r   <= {{(ITER-1){1'b0}}, 1'b1};
            m1x_r    <= a_ext_s;
            m3x_r    <= m3x_s;
            hi_r     <= '0;
            b_r      <= {{2{b_sign_s}}, multiplier};
            prev_r   <= 1'b0;
            sm_r     <= sign_mode;
            acc_en_r <= acc_en;
        end else if (state_r == ST_CALC) begin
            iter_r          <= {iter_r[ITER-2:0], 1'b0};
            {hi_r, b_r}     <= shifted_s;
            prev_r          <= b_r[1];
        end
    end

    // Result, accumulator and output-valid registers; clear beats the ACC write.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= '0;
            out_result_r <= '0;
            out_valid_r  <= 1'b0;
        end else begin
            if (state_r == ST_ACC) begin
                out_result_r <= result_s;
            end
            if (acc_clr) begin
                acc_r <= '0;
            end else if (state_r == ST_ACC) begin
                acc_r <= result_s;
            end
            out_valid_r <= (state_r == ST_HOLD) && !(out_valid_r && out_ready);
        end
    end

endmodule
